// File: rtl/sockit_spi_buf.sv
// Registered elastic stream buffer for vld/dat/rdy handshake streams.
// Every output is driven from flops (plus the flush/reset gating), so no
// combinational path exists between the two stream sides, including rdy.
// Storage is a circular buffer of DEPTH entries with an occupancy counter.
module sockit_spi_buf #(
    parameter type DT = logic [31:0],
    parameter int  DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    output logic [CW-1:0] cnt_o,
    input  logic          sti_vld_i,
    input  DT             sti_dat_i,
    output logic          sti_rdy_o,
    output logic          sto_vld_o,
    output DT             sto_dat_o,
    input  logic          sto_rdy_i
);

    // Pointer width; DEPTH=1 still gets a 1-bit pointer that simply stays at 0.
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Array sized to the full pointer range so any pointer value indexes safely;
    // only the first DEPTH entries are ever used because the pointers wrap early.
    localparam int MEM_N = 2 ** AW;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    generate
        if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
            $error("sockit_spi_buf: DEPTH must be within 1..16");
        end
    endgenerate

    DT             mem_q [MEM_N];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    // Handshake outputs: both are gated by reset and flush so that neither
    // side can transfer while the buffer is being cleared.
    assign sti_rdy_o = rst_ni & ~flush_i & (cnt_q != FULL);
    assign sto_vld_o = rst_ni & ~flush_i & (cnt_q != '0);
    assign sto_dat_o = mem_q[rptr_q];
    assign cnt_o     = cnt_q;

    assign push = sti_vld_i & sti_rdy_o;
    assign pop  = sto_vld_o & sto_rdy_i;

    // Next-state pointers and occupancy; pointers wrap at DEPTH-1 so that
    // non-power-of-two depths behave as a true circular buffer.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // Control state: reset wins over flush, flush wins over both stream sides.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Data storage is deliberately left unreset; push is already suppressed
    // during reset and flush, so stale contents are never presented as valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= sti_dat_i;
        end
    end

endmodule

// File: tb/tb_sockit_spi_buf.sv
// Self-checking bench: four buffers (DEPTH 1..4) run side by side against a
// queue-based reference model; directed phases plus a randomized phase.
module tb_sockit_spi_buf;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        sti_vld [N];
    logic [31:0] sti_dat [N];
    logic        sti_rdy [N];
    logic        sto_vld [N];
    logic [31:0] sto_dat [N];
    logic        sto_rdy [N];
    logic [2:0]  cnt     [N];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            logic [$clog2(gi + 2)-1:0] cnt_l;
            sockit_spi_buf #(.DEPTH(gi + 1)) u_dut (
                .clk_i     (clk),
                .rst_ni    (rst_n),
                .flush_i   (flush),
                .cnt_o     (cnt_l),
                .sti_vld_i (sti_vld[gi]),
                .sti_dat_i (sti_dat[gi]),
                .sti_rdy_o (sti_rdy[gi]),
                .sto_vld_o (sto_vld[gi]),
                .sto_dat_o (sto_dat[gi]),
                .sto_rdy_i (sto_rdy[gi])
            );
            assign cnt[gi] = 3'(cnt_l);
        end
    endgenerate

    // Reference model state: expected buffer contents per instance.
    logic [31:0] mq  [N][$];
    logic [31:0] src [N][$];
    logic        pushed [N];
    logic        popped [N];
    int          npush  [N];
    int          npop   [N];
    int          checks = 0;
    int          errors = 0;
    bit          rand_mode = 1'b0;
    bit          chaos = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Compare every instance against the model at the falling edge, then
    // advance the model by the transfers that the rising edge will perform.
    task automatic cycle();
        logic er, ev;
        int   d;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            d  = i + 1;
            er = rst_n && !flush && (mq[i].size() != d);
            ev = rst_n && !flush && (mq[i].size() != 0);
            chk($sformatf("d%0d_rdy", d), 32'(sti_rdy[i]), 32'(er));
            chk($sformatf("d%0d_vld", d), 32'(sto_vld[i]), 32'(ev));
            chk($sformatf("d%0d_cnt", d), 32'(cnt[i]), 32'(mq[i].size()));
            if (ev) chk($sformatf("d%0d_dat", d), sto_dat[i], mq[i][0]);
            pushed[i] = er && sti_vld[i];
            popped[i] = ev && sto_rdy[i];
            if (!rst_n || flush) begin
                mq[i].delete();
            end else begin
                if (popped[i]) begin
                    $display("d%0d pop %08h cnt %0d", d, mq[i][0], mq[i].size());
                    void'(mq[i].pop_front());
                    npop[i]++;
                end
                if (pushed[i]) begin
                    mq[i].push_back(sti_dat[i]);
                    npush[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            sti_vld[i] = (src[i].size() > 0);
            sti_dat[i] = (src[i].size() > 0) ? src[i][0] : 32'h0;
        end
    endtask

    // Producer holds vld/dat until accepted; random mode also randomizes the consumer.
    task automatic produce();
        for (int i = 0; i < N; i++) begin
            if (rand_mode) begin
                if (!sti_vld[i] || pushed[i]) begin
                    sti_vld[i] = ($urandom % 100) < 70;
                    sti_dat[i] = $urandom;
                end
                sto_rdy[i] = ($urandom % 100) < 60;
            end else if (pushed[i]) begin
                void'(src[i].pop_front());
            end
        end
        if (!rand_mode) present();
        if (chaos) begin
            rst_n = ($urandom % 100) >= 3;
            flush = ($urandom % 100) < 4;
        end
    endtask

    task automatic step();
        cycle();
        produce();
    endtask

    task automatic clr_src();
        for (int i = 0; i < N; i++) src[i].delete();
        present();
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < N; i++) begin
            npush[i] = 0;
            npop[i]  = 0;
        end
    endtask

    task automatic set_rdy(input logic v);
        for (int i = 0; i < N; i++) sto_rdy[i] = v;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < N; i++) begin
            pushed[i] = 1'b0;
            popped[i] = 1'b0;
            src[i].push_back(32'h11);
        end
        clr_cnt();
        set_rdy(1'b1);
        present();

        // Reset held with a valid producer: nothing may be accepted or offered.
        repeat (3) begin
            step();
            chk("rst_cnt", 32'(cnt[3]), 32'd0);
            chk("rst_rdy", 32'(sti_rdy[3]), 32'd0);
            chk("rst_vld", 32'(sto_vld[3]), 32'd0);
        end
        rst_n = 1'b1;
        clr_cnt();
        step();
        chk("first_push", 32'(npush[3]), 32'd1);
        chk("first_cnt", 32'(cnt[3]), 32'd1);

        flush = 1'b1;
        clr_src();
        step();
        flush = 1'b0;

        // Fill with the consumer stalled: DEPTH=4 takes A0..A3 and holds A4.
        set_rdy(1'b0);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 5; k++) src[i].push_back(32'hA0 + k);
        present();
        repeat (6) step();
        chk("full_cnt", 32'(cnt[3]), 32'd4);
        chk("full_rdy", 32'(sti_rdy[3]), 32'd0);
        chk("full_vld", 32'(sto_vld[3]), 32'd1);
        chk("full_dat", sto_dat[3], 32'hA0);

        // Release the consumer from full: first edge pops only, then 1 in + 1 out.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 7; k++) src[i].push_back(32'hB0 + k);
        present();
        set_rdy(1'b1);
        clr_cnt();
        step();
        chk("full_pop_only", 32'(npush[3]), 32'd0);
        chk("full_first_pop", 32'(npop[3]), 32'd1);
        repeat (7) step();
        chk("stream_pops", 32'(npop[3]), 32'd8);
        chk("stream_pushes", 32'(npush[3]), 32'd7);
        chk("stream_cnt", 32'(cnt[3]), 32'd3);

        flush = 1'b1;
        clr_src();
        step();
        flush = 1'b0;

        // DEPTH=2 flush while full and while the producer is still valid.
        set_rdy(1'b0);
        src[1].push_back(32'hC0);
        src[1].push_back(32'hC1);
        src[1].push_back(32'hC2);
        present();
        repeat (3) step();
        chk("d2_full_cnt", 32'(cnt[1]), 32'd2);
        flush = 1'b1;
        #1;
        chk("flush_rdy", 32'(sti_rdy[1]), 32'd0);
        chk("flush_vld", 32'(sto_vld[1]), 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_cnt", 32'(cnt[1]), 32'd0);
        chk("flush_empty", 32'(sto_vld[1]), 32'd0);
        src[1].delete();
        src[1].push_back(32'h55);
        present();
        step();
        chk("after_flush_vld", 32'(sto_vld[1]), 32'd1);
        chk("after_flush_dat", sto_dat[1], 32'h55);

        flush = 1'b1;
        clr_src();
        step();
        flush = 1'b0;

        // DEPTH=1 with both sides always ready: full and empty alternate.
        set_rdy(1'b1);
        for (int k = 0; k < 10; k++) src[0].push_back(32'hD0 + k);
        present();
        clr_cnt();
        repeat (10) step();
        chk("d1_pops", 32'(npop[0]), 32'd5);
        chk("d1_pushes", 32'(npush[0]), 32'd5);

        flush = 1'b1;
        clr_src();
        step();
        flush = 1'b0;

        // Random traffic until DEPTH=3 has delivered 1000 words.
        rand_mode = 1'b1;
        clr_cnt();
        cyc = 0;
        while (npop[2] < 1000 && cyc < 20000) begin
            step();
            cyc++;
        end
        chk("rand_words_done", 32'(npop[2] >= 1000), 32'd1);

        // Random traffic with sporadic reset and flush mid-operation.
        chaos = 1'b1;
        repeat (300) step();
        chaos = 1'b0;
        rst_n = 1'b1;
        flush = 1'b0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
